// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one single-port sync memory shared by IF, LS and EXT.
// Define ARB_RR_EN for round-robin arbitration instead of LS > IF > EXT.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [3:0]        ls_be,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_gnt,
  output logic              ls_done,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [3:0]        ext_be,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [31:0]       ext_wdata,
  output logic              ext_gnt,
  output logic              ext_done,
  output logic [31:0]       rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [1:0] O_NONE = 2'd0;
  localparam logic [1:0] O_IF   = 2'd1;
  localparam logic [1:0] O_LS   = 2'd2;
  localparam logic [1:0] O_EXT  = 2'd3;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       win;

`ifdef ARB_RR_EN
  // ptr names the requester the search starts from
  logic [1:0] ptr;

  function automatic logic [1:0] after(input logic [1:0] o);
    logic [1:0] n;
    unique case (o)
      O_LS:    n = O_IF;
      O_IF:    n = O_EXT;
      default: n = O_LS;
    endcase
    return n;
  endfunction

  always_comb begin
    win = O_NONE;
    unique case (ptr)
      O_IF: begin
        if (if_req)       win = O_IF;
        else if (ext_req) win = O_EXT;
        else if (ls_req)  win = O_LS;
      end
      O_EXT: begin
        if (ext_req)     win = O_EXT;
        else if (ls_req) win = O_LS;
        else if (if_req) win = O_IF;
      end
      default: begin
        if (ls_req)       win = O_LS;
        else if (if_req)  win = O_IF;
        else if (ext_req) win = O_EXT;
      end
    endcase
  end
`else
  always_comb begin
    win = O_NONE;
    if (ls_req)       win = O_LS;
    else if (if_req)  win = O_IF;
    else if (ext_req) win = O_EXT;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      if_gnt    <= 1'b0;
      if_done   <= 1'b0;
      ls_gnt    <= 1'b0;
      ls_done   <= 1'b0;
      ext_gnt   <= 1'b0;
      ext_done  <= 1'b0;
      rdata     <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      owner     <= O_NONE;
`ifdef ARB_RR_EN
      ptr       <= O_LS;
`endif
    end else begin
      if_gnt   <= 1'b0;
      ls_gnt   <= 1'b0;
      ext_gnt  <= 1'b0;
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      ext_done <= 1'b0;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      mem_be   <= '0;
      unique case (state)
        IDLE, DONE: begin
          if (win != O_NONE) begin
            state  <= ISSUE;
            busy   <= 1'b1;
            owner  <= win;
            mem_en <= 1'b1;
`ifdef ARB_RR_EN
            ptr    <= after(win);
`endif
            unique case (win)
              O_IF: begin
                if_gnt    <= 1'b1;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
              end
              O_LS: begin
                ls_gnt    <= 1'b1;
                mem_we    <= ls_we;
                mem_be    <= ls_be;
                mem_addr  <= ls_addr;
                mem_wdata <= ls_wdata;
              end
              default: begin
                ext_gnt   <= 1'b1;
                mem_we    <= ext_we;
                mem_be    <= ext_be;
                mem_addr  <= ext_addr;
                mem_wdata <= ext_wdata;
              end
            endcase
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            owner <= O_NONE;
          end
        end
        ISSUE: begin
          state <= WAIT;
          cnt   <= CNT_W'(MEM_LAT);
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state    <= DONE;
            rdata    <= mem_rdata;
            if_done  <= (owner == O_IF);
            ls_done  <= (owner == O_LS);
            ext_done <= (owner == O_EXT);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
